naneye_pixel_framer: RTL
========================

// Module: naneye_pixel_framer
// PURPOSE
// - Consumes the decoded serial bit stream (OUTPUT/OUTPUT_EN) from the RX decoder in the sensor RX path.
// - Finds the frame-sync run, checks 12-bit word framing and extracts 10-bit pixels.
// - Tags each pixel with start-of-frame, end-of-line and end-of-frame flags.
// - Feeds the downstream pixel/line-buffer logic in the SCLOCK domain.
// PARAMETERS
// - COLS      250  pixels per line
// - ROWS      250  lines per frame
// - SYNC_ONES 24   minimum consecutive valid '1' bits accepted as the frame-sync run
// PORTS
// - SCLOCK      in   1   sample clock; the only clock
// - RESET       in   1   synchronous, active-high
// - SER_IN      in   1   decoded data bit
// - SER_IN_EN   in   1   SER_IN valid this cycle; bits arrive MSB-first
// - PIX_DATA    out  10  pixel value
// - PIX_VALID   out  1   1-cycle strobe; PIX_DATA/flags are valid
// - PIX_SOF     out  1   with PIX_VALID: first pixel of the frame (col 0, row 0)
// - PIX_EOL     out  1   with PIX_VALID: col == COLS-1
// - PIX_EOF     out  1   with PIX_VALID: last pixel (col COLS-1, row ROWS-1)
// - FRAME_ERR   out  1   1-cycle pulse on a framing error
// - IN_FRAME    out  1   high while in DATA state
// - FRAME_CNT   out  16  completed frames, wraps 0xFFFF->0
// - ERR_CNT     out  16  framing-error count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: every output is 0, state = HUNT, all counters = 0.
// - RESET takes effect mid-word and mid-frame; the partial word is discarded and no strobe is issued.
// - Cycles with SER_IN_EN=0 are ignored by every counter and by the FSM.
// - Word format, 12 bits: bit11 = start = '1'; bits 10..1 = pixel, MSB first; bit0 = stop = '0'.
// - HUNT: counts consecutive valid '1's in run_cnt, which saturates at SYNC_ONES.
//   - A valid '0' with run_cnt >= SYNC_ONES -> DATA: bit_cnt=0, col=0, row=0.
//   - A valid '0' with run_cnt < SYNC_ONES clears run_cnt and stays in HUNT.
// - DATA: shifts valid bits into a 12-bit shift register; bit_cnt runs 0..11.
//   - On the 12th bit, check start=='1' and stop=='0'.
//   - Good word: next cycle PIX_VALID=1 and PIX_DATA=bits 10..1. Latency is 1 SCLOCK after the stop bit's SER_IN_EN.
//   - Flags are set from col/row before they advance. col wraps at COLS-1 and row then increments.
//   - After the PIX_EOF word: FRAME_CNT+1, -> HUNT with run_cnt=0.
//   - Bad word: FRAME_ERR pulses 1 cycle after the 12th bit, no PIX_VALID, ERR_CNT+1, -> HUNT with run_cnt=0.
// - A sync run seen inside DATA is treated as data and caught as a framing error. There is no mid-frame resync.
// - SER_IN_EN high every cycle is legal. PIX_VALID pulses are then at least 12 cycles apart.
// - There is no back-pressure; the consumer must accept every PIX_VALID.
// - IN_FRAME is high from the cycle after the DATA entry until the cycle after the EOF strobe or FRAME_ERR.
// CONFIGURATION
// - Macro FRAMER_ERRCNT_EN.
// - Defined: ERR_CNT is a 16-bit counter, saturating at 0xFFFF, cleared only by RESET.
// - Undefined: ERR_CNT is tied to 0 and no counter logic is built. FRAME_ERR is unchanged.
// TESTING
// - Bench parameters: COLS=4, ROWS=2, SYNC_ONES=8; SER_IN_EN=1 continuously.
// - Scenario 1, good frame:
//   - Stimulus: 8 ones, then a '0', then 8 good words with pixels 0x001..0x008.
//   - Required: 8 PIX_VALID in order; SOF on 0x001; EOL on 0x004 and 0x008; EOF on 0x008.
//   - Required: FRAME_CNT=1 and IN_FRAME low afterwards.
// - Scenario 2, short sync:
//   - Stimulus: 7 ones then a '0', then words.
//   - Required: stays in HUNT; no PIX_VALID; FRAME_ERR never asserts.
// - Scenario 3, bad stop bit:
//   - Stimulus: 3rd word with stop='1'.
//   - Required: FRAME_ERR pulse, no 3rd PIX_VALID, return to HUNT.
//   - Required: ERR_CNT=1 with the macro defined, 0 without it. A following valid frame is received correctly.
// - Scenario 4, gapped enable:
//   - Stimulus: SER_IN_EN toggles 1/0 every cycle, same data as scenario 1.
//   - Required: identical pixel sequence; each strobe comes 1 cycle after the stop bit.
// - Scenario 5, reset mid-word:
//   - Stimulus: RESET asserted for 1 cycle at bit 6 of word 2.
//   - Required: all outputs 0 the next cycle; no strobe; the next frame decodes cleanly.
// - Scenario 6, counter wrap:
//   - Stimulus: force FRAME_CNT=0xFFFF, then complete one frame.
//   - Required: FRAME_CNT=0x0000.

Source files
------------

// File: rtl/naneye_pixel_framer_if.sv
// Signal bundle between the RX decoder, the pixel framer and the pixel/line-buffer logic.
// The framer is the slave side; the decoder/consumer pair (or a bench) is the master side.
interface naneye_pixel_framer_if;
  logic        SER_IN;
  logic        SER_IN_EN;
  logic [9:0]  PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_SOF;
  logic        PIX_EOL;
  logic        PIX_EOF;
  logic        FRAME_ERR;
  logic        IN_FRAME;
  logic [15:0] FRAME_CNT;
  logic [15:0] ERR_CNT;

  modport master (
    output SER_IN, SER_IN_EN,
    input  PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    input  FRAME_ERR, IN_FRAME, FRAME_CNT, ERR_CNT
  );

  modport slave (
    input  SER_IN, SER_IN_EN,
    output PIX_DATA, PIX_VALID, PIX_SOF, PIX_EOL, PIX_EOF,
    output FRAME_ERR, IN_FRAME, FRAME_CNT, ERR_CNT
  );
endinterface

// File: rtl/naneye_pixel_framer.sv
// NanEye pixel framer: hunts the sync run, frames 12-bit words into tagged 10-bit pixels.
// Define FRAMER_ERRCNT_EN to build the saturating framing-error counter behind ERR_CNT.
module naneye_pixel_framer #(
  parameter int COLS      = 250,
  parameter int ROWS      = 250,
  parameter int SYNC_ONES = 24
) (
  input  logic                  SCLOCK,
  input  logic                  RESET,
  naneye_pixel_framer_if.slave  bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(SYNC_ONES + 1);

  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   run_cnt_q, run_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [10:0]     shift_q;
  logic [9:0]      pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_sof_q, pix_sof_d;
  logic            pix_eol_q, pix_eol_d;
  logic            pix_eof_q, pix_eof_d;
  logic            frame_err_q, frame_err_d;
  logic            in_frame_q, in_frame_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic [11:0]     word;
  logic            word_done, word_good, last_col, last_row;

  // The incoming bit completes the word together with the 11 bits already shifted in.
  assign word      = {shift_q, bus.SER_IN};
  assign word_done = (state_q == DATA) && bus.SER_IN_EN && (bit_cnt_q == 4'd11);
  assign word_good = word[11] && !word[0];
  assign last_col  = (col_q == CW'(COLS - 1));
  assign last_row  = (row_q == RW'(ROWS - 1));

  always_ff @(posedge SCLOCK) begin
    if (RESET) begin
      state_q     <= HUNT;
      run_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      pix_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_sof_q   <= pix_sof_d;
      pix_eol_q   <= pix_eol_d;
      pix_eof_q   <= pix_eof_d;
      frame_err_q <= frame_err_d;
      in_frame_q  <= in_frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge SCLOCK) begin
    if (bus.SER_IN_EN) shift_q <= word[10:0];
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    bit_cnt_d = bit_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    if (bus.SER_IN_EN) begin
      case (state_q)
        HUNT: begin
          if (bus.SER_IN) begin
            if (run_cnt_q < SW'(SYNC_ONES)) run_cnt_d = run_cnt_q + 1'b1;
          end else if (run_cnt_q >= SW'(SYNC_ONES)) begin
            state_d   = DATA;
            run_cnt_d = '0;
            bit_cnt_d = '0;
            col_d     = '0;
            row_d     = '0;
          end else begin
            run_cnt_d = '0;
          end
        end
        DATA: begin
          if (bit_cnt_q != 4'd11) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = '0;
            // A bad word or the last pixel both end the frame; no mid-frame resync.
            if (!word_good || (last_col && last_row)) begin
              state_d   = HUNT;
              run_cnt_d = '0;
            end else if (last_col) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Flags come from col/row before they advance; IN_FRAME lingers for the strobe cycle.
  always_comb begin
    pix_valid_d = word_done && word_good;
    pix_data_d  = pix_valid_d ? word[10:1] : pix_data_q;
    pix_sof_d   = pix_valid_d && (col_q == '0) && (row_q == '0);
    pix_eol_d   = pix_valid_d && last_col;
    pix_eof_d   = pix_eol_d && last_row;
    frame_err_d = word_done && !word_good;
    in_frame_d  = (state_d == DATA) || (state_q == DATA);
    frame_cnt_d = frame_cnt_q + {15'd0, pix_eof_d};
  end

`ifdef FRAMER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge SCLOCK) begin
    if (RESET) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign bus.ERR_CNT = err_cnt_q;
`else
  assign bus.ERR_CNT = 16'd0;
`endif

  assign bus.PIX_DATA  = pix_data_q;
  assign bus.PIX_VALID = pix_valid_q;
  assign bus.PIX_SOF   = pix_sof_q;
  assign bus.PIX_EOL   = pix_eol_q;
  assign bus.PIX_EOF   = pix_eof_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.IN_FRAME  = in_frame_q;
  assign bus.FRAME_CNT = frame_cnt_q;
endmodule
